posit_encoder: RTL and testbench
================================

// Module: posit_encoder
// PURPOSE
//  Packs an unpacked posit value (sign, signed scale, fraction after the hidden one, sticky) into an N-bit posit.
//  Applies round-to-nearest-even, saturates to maxpos/minpos and two's-complements negative results.
//  Sits at the back end of every posit arithmetic unit, after the normalise/LZD step; it is the inverse of the regime-decode path.
//  Two-stage pipeline with valid/ready flow control.
// PARAMETERS
//  N      16               posit width in bits (>=8)
//  ES     1                exponent field width (0..4)
//  FRAC_W N                input fraction width, MSB-aligned, hidden one excluded
//  SW     $clog2(N)+ES+2   signed scale width
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       synchronous reset, active high
//  in_valid    in   1       input operand valid
//  in_ready    out  1       encoder can accept an operand this cycle
//  in_sign     in   1       1 = negative
//  in_scale    in   SW      signed scale; value = 2^scale * 1.frac
//  in_frac     in   FRAC_W  fraction bits after the hidden one
//  in_sticky   in   1       OR of fraction bits below in_frac
//  in_zero     in   1       operand is exactly zero (other fields ignored)
//  in_nar      in   1       operand is NaR (priority over in_zero)
//  out_valid   out  1       out_posit valid
//  out_ready   in   1       downstream accepts out_posit
//  out_posit   out  N       encoded posit
// BEHAVIOUR
//  - Reset: s1_valid = s2_valid = 0, out_valid = 0, out_posit = 0. in_ready = 1 in the cycle after rst deasserts.
//  - rst mid-operation discards both stages; the data registers keep their values but are never presented.
//  - Transfer rules: an input transfers when in_valid & in_ready; an output transfers when out_valid & out_ready.
//    adv2 = ~s2_valid | out_ready; adv1 = ~s1_valid | adv2; in_ready = adv1 (combinational path from out_ready).
//  - Latency is 2 cycles when not stalled, throughput 1/cycle. When stalled, out_posit holds stable while out_valid=1.
//  - Stage 1 (register on adv1):
//    - k = in_scale >>> ES (arithmetic); e = in_scale[ES-1:0].
//    - Regime: k>=0 gives k+1 ones then a 0; k<0 gives -k zeros then a 1.
//    - Build {regime, e, in_frac} and right-shift it into an N-1 bit body plus a guard bit.
//      The shifted-out bits OR in_sticky form the sticky bit.
//    - Saturation flags: sat_hi when k >= N-2; sat_lo when k <= -(N-1).
//  - Stage 2 (register on adv2):
//    - Rounding: round_up = guard & (lsb | sticky).
//    - If body == all-ones and round_up, hold at maxpos (never rounds to NaR).
//    - If the result is zero and not in_zero, force minpos (never rounds to zero).
//    - Saturation: sat_hi gives mag = {1'b0,{N-1{1'b1}}}; sat_lo gives mag = 1. Saturation overrides rounding.
//    - Sign: out = sign ? -mag : mag, with {1'b0, mag} forming the N-bit value.
//    - Specials: in_nar gives {1'b1,{N-1{1'b0}}}; in_zero gives 0. Both bypass rounding and the sign step.
//  - Simultaneous accept and emit in the same cycle is legal; no bubble is inserted.
// STRUCTURE
//  - posit_pkg holds:
//    - the maxpos/minpos/NaR constant functions of N;
//    - the scale-width function;
//    - a typedef for the unpacked struct {sign, scale, frac, sticky, zero, nar}.
//  - One sub-module, posit_regime_shifter: stage-1 combinational regime build, shift and sticky OR.
//    The encoder instantiates it and owns both pipeline registers and the handshake.
// TESTING (N=16, ES=1, FRAC_W=16)
//  - scale=0, frac=0, sign=0 -> 0x4000; scale=1 -> 0x5000; scale=-1 -> 0x3000; sign=1, scale=0 -> 0xC000.
//  - Round to nearest even, scale=0:
//    - frac=0x0008, sticky=0 -> 0x4000 (tie, round down);
//    - frac=0x0018 -> 0x4002 (tie, round up);
//    - frac=0x0008, sticky=1 -> 0x4001.
//  - Saturation: scale=+100 -> 0x7FFF; scale=-100 -> 0x0001; sign=1, scale=+100 -> 0x8001.
//  - Specials: in_nar=1 -> 0x8000; in_zero=1, sign=1 -> 0x0000.
//  - Backpressure:
//    - 4 back-to-back inputs with out_ready low for 3 cycles -> in_ready drops after 2 accepts.
//    - Outputs emerge in order with no loss or duplicate, and out_posit is stable while stalled.
//  - Reset with both stages full -> out_valid=0 the next cycle; the first new input appears 2 cycles after it is accepted.

Source files
------------

// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared posit constants, scale-width helper and unpacked operand type
package posit_pkg;

  // Signed scale width able to hold every regime/exponent combination of an n-bit posit
  function automatic int posit_scale_w(input int n, input int es);
    return $clog2(n) + es + 2;
  endfunction

  // Largest positive posit: 0111...1
  function automatic logic [63:0] posit_maxpos(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // Smallest positive posit: 000...1
  function automatic logic [63:0] posit_minpos(input int n);
    return 64'd1 & ((64'd1 << n) - 64'd1);
  endfunction

  // Not-a-Real: 1000...0
  function automatic logic [63:0] posit_nar(input int n);
    return 64'd1 << (n - 1);
  endfunction

  localparam int PKG_N      = 16;
  localparam int PKG_ES     = 1;
  localparam int PKG_FRAC_W = PKG_N;
  localparam int PKG_SW     = posit_scale_w(PKG_N, PKG_ES);

  // Unpacked operand as produced by the normalise/LZD stage (default 16-bit geometry)
  typedef struct packed {
    logic                     sign;
    logic signed [PKG_SW-1:0] scale;
    logic [PKG_FRAC_W-1:0]    frac;
    logic                     sticky;
    logic                     zero;
    logic                     nar;
  } posit_unpacked_t;

endpackage

// File: rtl/posit_regime_shifter.sv
// rtl/posit_regime_shifter.sv - builds {regime, exponent, fraction} and cuts it into body, guard and sticky
module posit_regime_shifter
  import posit_pkg::*;
#(
  parameter int N      = 16,
  parameter int ES     = 1,
  parameter int FRAC_W = N,
  parameter int SW     = posit_scale_w(N, ES)
) (
  input  logic [SW-1:0]     i_scale,
  input  logic [FRAC_W-1:0] i_frac,
  input  logic              i_sticky,
  output logic [N-2:0]      o_body,
  output logic              o_guard,
  output logic              o_sticky,
  output logic              o_sat_hi,
  output logic              o_sat_lo
);

  localparam int L  = 2 + ES + FRAC_W;
  // N extra low bits catch everything shifted out by any non-saturating regime
  localparam int WV = L + N;
  localparam logic signed [SW-1:0] K_HI   = SW'(N - 2);
  localparam logic signed [SW-1:0] K_LO   = SW'(1 - N);
  localparam logic        [SW-1:0] SH_MAX = SW'(N - 1);

  logic signed [SW-1:0]    w_k;
  logic                    w_k_neg;
  logic [SW-1:0]           w_sh_raw;
  logic [SW-1:0]           w_sh;
  logic [ES+FRAC_W-1:0]    w_ef;
  logic [WV-1:0]           w_base;
  logic [WV-1:0]           w_fill;
  logic [WV-1:0]           w_vec;

  // Regime run: start from the two terminating regime bits and shift right, filling with
  // ones for k>=0 (shift k) or zeros for k<0 (shift -k-1 == ~k)
  always_comb begin
    w_k      = $signed(i_scale) >>> ES;
    w_k_neg  = w_k[SW-1];
    w_sh_raw = w_k_neg ? ~w_k : w_k;
    w_sh     = (w_sh_raw > SH_MAX) ? SH_MAX : w_sh_raw;
    w_ef     = (ES + FRAC_W)'({i_scale, i_frac});
    w_base   = {(w_k_neg ? 2'b01 : 2'b10), w_ef, {N{1'b0}}};
    w_fill   = w_k_neg ? '0 : ~({WV{1'b1}} >> w_sh);
    w_vec    = (w_base >> w_sh) | w_fill;
    o_body   = w_vec[WV-1 -: N-1];
    o_guard  = w_vec[WV-N];
    o_sticky = (|w_vec[WV-N-1:0]) | i_sticky;
    o_sat_hi = (w_k >= K_HI);
    o_sat_lo = (w_k <= K_LO);
  end

endmodule

// File: rtl/posit_encoder.sv
// rtl/posit_encoder.sv - two-stage posit packer with RNE rounding, saturation and valid/ready flow
module posit_encoder
  import posit_pkg::*;
#(
  parameter int N      = 16,
  parameter int ES     = 1,
  parameter int FRAC_W = N,
  parameter int SW     = posit_scale_w(N, ES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [SW-1:0]     in_scale,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic              in_sticky,
  input  logic              in_zero,
  input  logic              in_nar,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_posit
);

  localparam logic [N-1:0] C_MAXPOS   = N'(posit_maxpos(N));
  localparam logic [N-1:0] C_MINPOS   = N'(posit_minpos(N));
  localparam logic [N-1:0] C_NAR      = N'(posit_nar(N));
  localparam logic [N-2:0] C_BODY_MAX = C_MAXPOS[N-2:0];
  localparam logic [N-2:0] C_BODY_MIN = C_MINPOS[N-2:0];

  logic         w_adv1;
  logic         w_adv2;
  logic [N-2:0] w_body;
  logic         w_guard;
  logic         w_sticky;
  logic         w_sat_hi;
  logic         w_sat_lo;
  logic         w_round_up;
  logic [N-2:0] w_mag;
  logic [N-1:0] w_val;
  logic [N-1:0] w_enc;

  logic         r_s1_valid;
  logic         r_s1_sign;
  logic         r_s1_zero;
  logic         r_s1_nar;
  logic [N-2:0] r_s1_body;
  logic         r_s1_guard;
  logic         r_s1_sticky;
  logic         r_s1_sat_hi;
  logic         r_s1_sat_lo;
  logic         r_s2_valid;
  logic [N-1:0] r_out_posit;

  // A stage may load when it is empty or its content leaves this cycle
  assign w_adv2    = ~r_s2_valid | out_ready;
  assign w_adv1    = ~r_s1_valid | w_adv2;
  assign in_ready  = w_adv1;
  assign out_valid = r_s2_valid;
  assign out_posit = r_out_posit;

  posit_regime_shifter #(
    .N      (N),
    .ES     (ES),
    .FRAC_W (FRAC_W),
    .SW     (SW)
  ) u_shifter (
    .i_scale  (in_scale),
    .i_frac   (in_frac),
    .i_sticky (in_sticky),
    .o_body   (w_body),
    .o_guard  (w_guard),
    .o_sticky (w_sticky),
    .o_sat_hi (w_sat_hi),
    .o_sat_lo (w_sat_lo)
  );

  // Stage-1 occupancy
  always_ff @(posedge clk) begin
    if (rst) r_s1_valid <= 1'b0;
    else if (w_adv1) r_s1_valid <= in_valid;
  end

  // Stage-1 data, captured only on an input transfer and never cleared by reset
  always_ff @(posedge clk) begin
    if (w_adv1 && in_valid) begin
      r_s1_sign   <= in_sign;
      r_s1_zero   <= in_zero;
      r_s1_nar    <= in_nar;
      r_s1_body   <= w_body;
      r_s1_guard  <= w_guard;
      r_s1_sticky <= w_sticky;
      r_s1_sat_hi <= w_sat_hi;
      r_s1_sat_lo <= w_sat_lo;
    end
  end

  // Round to nearest even, clamp to [minpos, maxpos], apply sign, then specials win
  always_comb begin
    w_round_up = r_s1_guard & (r_s1_body[0] | r_s1_sticky);
    w_mag      = r_s1_body;
    if (w_round_up && (r_s1_body != C_BODY_MAX)) w_mag = r_s1_body + (N-1)'(1);
    if (r_s1_sat_hi) w_mag = C_BODY_MAX;
    else if (r_s1_sat_lo) w_mag = C_BODY_MIN;
    if (w_mag == '0) w_mag = C_BODY_MIN;
    w_val = {1'b0, w_mag};
    w_enc = r_s1_sign ? (~w_val + N'(1)) : w_val;
    if (r_s1_nar) w_enc = C_NAR;
    else if (r_s1_zero) w_enc = '0;
  end

  // Stage-2 occupancy and output register; output holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_out_posit <= '0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_out_posit <= w_enc;
    end
  end

endmodule

// File: tb/tb_posit_encoder.sv
// tb/tb_posit_encoder.sv - self-checking bench for posit_encoder (N=16, ES=1, FRAC_W=16)
module tb_posit_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_scale;
  logic [15:0] in_frac;
  logic        in_sticky;
  logic        in_zero;
  logic        in_nar;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_posit;

  int checks = 0;
  int errors = 0;

  // SW widened to 8 so that scale values of +/-100 are representable
  posit_encoder #(.N(16), .ES(1), .FRAC_W(16), .SW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_scale  (in_scale),
    .in_frac   (in_frac),
    .in_sticky (in_sticky),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    int          scale;
    logic [15:0] frac;
    logic        sticky;
    logic        zero;
    logic        nar;
    logic [15:0] exp;
    string       name;
  } vec_t;

  function automatic vec_t mk(input logic s, input int sc, input logic [15:0] f, input logic st,
                              input logic z, input logic n, input logic [15:0] e, input string nm);
    vec_t v;
    v.sign = s; v.scale = sc; v.frac = f; v.sticky = st; v.zero = z; v.nar = n; v.exp = e; v.name = nm;
    return v;
  endfunction

  // Reference: write the posit bit string out as a list, cut after 15 bits, round half-even on the rest
  function automatic logic [15:0] ref_enc(input logic sign, input int scale, input logic [15:0] frac,
                                          input logic sticky, input logic zero, input logic nar);
    int k, e, body, g, st;
    logic q[$];
    logic [15:0] mag;
    if (nar) return 16'h8000;
    if (zero) return 16'h0000;
    k = (scale >= 0) ? scale / 2 : -((1 - scale) / 2);
    e = scale - 2 * k;
    if (k >= 14) mag = 16'h7FFF;
    else if (k <= -15) mag = 16'h0001;
    else begin
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      q.push_back(e[0]);
      for (int i = 15; i >= 0; i--) q.push_back(frac[i]);
      body = 0;
      for (int i = 0; i < 15; i++) body = body * 2 + int'(q[i]);
      g  = int'(q[15]);
      st = int'(sticky);
      for (int i = 16; i < q.size(); i++) st = st | int'(q[i]);
      if (g == 1 && ((body % 2) == 1 || st != 0) && body != 32'h7FFF) body = body + 1;
      if (body == 0) body = 1;
      mag = 16'(body);
    end
    return sign ? (16'h0000 - mag) : mag;
  endfunction

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_sign = 1'b0; in_scale = '0; in_frac = '0; in_sticky = 1'b0; in_zero = 1'b0; in_nar = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_in_rst got %b want 0", out_valid); end
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_posit !== 16'h0000) begin errors++; $display("FAIL reset_out_posit got %h want 0000", out_posit); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed;
    vec_t v[$];
    int lat;
    v.push_back(mk(0,    0, 16'h0000, 0, 0, 0, 16'h4000, "one"));
    v.push_back(mk(0,    1, 16'h0000, 0, 0, 0, 16'h5000, "two"));
    v.push_back(mk(0,   -1, 16'h0000, 0, 0, 0, 16'h3000, "half"));
    v.push_back(mk(1,    0, 16'h0000, 0, 0, 0, 16'hC000, "neg_one"));
    v.push_back(mk(0,    0, 16'h0008, 0, 0, 0, 16'h4000, "rne_tie_down"));
    v.push_back(mk(0,    0, 16'h0018, 0, 0, 0, 16'h4002, "rne_tie_up"));
    v.push_back(mk(0,    0, 16'h0008, 1, 0, 0, 16'h4001, "rne_sticky"));
    v.push_back(mk(0,  100, 16'h0000, 0, 0, 0, 16'h7FFF, "sat_hi"));
    v.push_back(mk(0, -100, 16'h0000, 0, 0, 0, 16'h0001, "sat_lo"));
    v.push_back(mk(1,  100, 16'h0000, 0, 0, 0, 16'h8001, "sat_hi_neg"));
    v.push_back(mk(0,    5, 16'h1234, 0, 0, 1, 16'h8000, "nar"));
    v.push_back(mk(1,    5, 16'h1234, 0, 1, 0, 16'h0000, "zero_neg"));
    v.push_back(mk(0,   26, 16'h0000, 0, 0, 0, 16'h7FFE, "k13_edge"));
    v.push_back(mk(0,   27, 16'h0000, 0, 0, 0, 16'h7FFE, "k13_tie_even"));
    v.push_back(mk(0,   27, 16'h0001, 0, 0, 0, 16'h7FFF, "k13_round_max"));
    v.push_back(mk(0,  -28, 16'h0000, 0, 0, 0, 16'h0001, "kneg14_edge"));
    v.push_back(mk(0,  -27, 16'h0000, 0, 0, 0, 16'h0002, "kneg14_round"));
    v.push_back(mk(0,  -30, 16'h0000, 0, 0, 0, 16'h0001, "kneg15_sat"));
    foreach (v[i]) begin
      @(negedge clk);
      in_sign = v[i].sign; in_scale = 8'(v[i].scale); in_frac = v[i].frac;
      in_sticky = v[i].sticky; in_zero = v[i].zero; in_nar = v[i].nar;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (out_valid !== 1'b1 || out_posit !== v[i].exp) begin
        errors++;
        $display("FAIL %s got %h (valid %b) want %h", v[i].name, out_posit, out_valid, v[i].exp);
      end
      checks++;
      if (lat != 2) begin errors++; $display("FAIL %s_latency got %0d want 2", v[i].name, lat); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [15:0] expq[$];
    logic [15:0] held, e;
    logic        stalled, taken;
    int          sent, recv, cur_scale;
    sent = 0; recv = 0; stalled = 1'b0; taken = 1'b0; held = '0;
    in_valid = 1'b0;
    for (int c = 0; c < 40 && recv < 4; c++) begin
      @(negedge clk);
      if (taken) begin in_valid = 1'b0; taken = 1'b0; end
      if (!in_valid && sent < 4) begin
        cur_scale = $urandom_range(0, 40) - 20;
        in_sign = 1'($urandom); in_scale = 8'(cur_scale); in_frac = 16'($urandom);
        in_sticky = 1'($urandom); in_zero = 1'b0; in_nar = 1'b0; in_valid = 1'b1;
      end
      out_ready = (c >= 3);
      #1;
      if (c == 2) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_drop got %b want 0", in_ready); end
        checks++;
        if (sent != 2) begin errors++; $display("FAIL bp_accepts got %0d want 2", sent); end
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_posit !== held) begin
          errors++; $display("FAIL bp_stall_stable got %h want %h", out_posit, held);
        end
      end
      stalled = out_valid && !out_ready;
      held    = out_posit;
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin errors++; $display("FAIL bp_extra_output got %h want none", out_posit); end
        else begin
          e = expq.pop_front();
          if (out_posit !== e) begin errors++; $display("FAIL bp_order got %h want %h", out_posit, e); end
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(ref_enc(in_sign, cur_scale, in_frac, in_sticky, in_zero, in_nar));
        sent++; taken = 1'b1;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (recv != 4 || expq.size() != 0) begin
      errors++; $display("FAIL bp_count got %0d want 4", recv);
    end
  endtask

  task automatic test_reset_midflight;
    logic [15:0] e;
    int          sc;
    @(negedge clk);
    out_ready = 1'b0;
    in_sign = 1'b0; in_scale = 8'(3); in_frac = 16'hAAAA; in_sticky = 1'b0; in_zero = 1'b0; in_nar = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_scale = 8'(-5);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_fill got valid %b ready %b want 1 0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_flush_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_flush_ready got %b want 1", in_ready); end
    sc = -9;
    in_sign = 1'b1; in_scale = 8'(sc); in_frac = 16'h0F0F; in_sticky = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    e = ref_enc(1'b1, sc, 16'h0F0F, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_new_early got %b want 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_posit !== e) begin
      errors++; $display("FAIL rst_new_data got %h (valid %b) want %h", out_posit, out_valid, e);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_ghost got %b want 0", out_valid); end
  endtask

  task automatic test_random;
    localparam int NUM = 300;
    logic [15:0] expq[$];
    logic [15:0] held, e;
    logic        stalled, taken;
    int          sent, recv, cyc, cur_scale;
    sent = 0; recv = 0; cyc = 0; stalled = 1'b0; taken = 1'b0; held = '0; cur_scale = 0;
    in_valid = 1'b0;
    while (recv < NUM && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (taken) begin in_valid = 1'b0; taken = 1'b0; end
      if (!in_valid && sent < NUM && $urandom_range(0, 4) != 0) begin
        if ($urandom_range(0, 9) == 0) cur_scale = $urandom_range(0, 255) - 128;
        else cur_scale = $urandom_range(0, 64) - 32;
        in_sign = 1'($urandom); in_scale = 8'(cur_scale); in_frac = 16'($urandom);
        in_sticky = 1'($urandom);
        in_zero = ($urandom_range(0, 19) == 0);
        in_nar  = ($urandom_range(0, 19) == 0);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_posit !== held) begin
          errors++; $display("FAIL rnd_stall_stable got %h want %h", out_posit, held);
        end
      end
      stalled = out_valid && !out_ready;
      held    = out_posit;
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin errors++; $display("FAIL rnd_extra_output got %h want none", out_posit); end
        else begin
          e = expq.pop_front();
          if (out_posit !== e) begin errors++; $display("FAIL rnd_data got %h want %h", out_posit, e); end
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(ref_enc(in_sign, cur_scale, in_frac, in_sticky, in_zero, in_nar));
        sent++; taken = 1'b1;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (recv != NUM || expq.size() != 0) begin
      errors++; $display("FAIL rnd_count got %0d want %0d", recv, NUM);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
